// File: rtl/gunzip_stored_if.sv
// Stream and status bundle for the stored-block gzip decoder.
// The decoder connects through the slave modport and its driver through the master modport.
interface gunzip_stored_if;
    logic [31:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic        done;
    logic        error;
    logic [2:0]  err_code;
    logic [31:0] crc32;
    logic [31:0] isize;

    modport slave (
        input  s_axis_tdata, s_axis_tvalid, m_axis_tready,
        output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast,
        output done, error, err_code, crc32, isize
    );

    modport master (
        output s_axis_tdata, s_axis_tvalid, m_axis_tready,
        input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast,
        input  done, error, err_code, crc32, isize
    );
endinterface

// File: rtl/gunzip_stored.sv
// Decodes a gzip member made only of stored blocks into a byte stream and checks CRC32 and ISIZE.
// Latency: a payload byte consumed in cycle N is presented on m_axis in cycle N+1.
// Backpressure: m_axis stalls hold the output register and stop payload consumption; header bytes never stall.
module gunzip_stored (
    input  logic           core_clock,
    input  logic           rst_n,
    gunzip_stored_if.slave bus
);

    typedef enum logic [2:0] {
        S_HDR, S_BLK, S_LEN, S_DATA, S_TRL, S_DONE, S_ERR
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  code_d;
    logic [31:0] hold_q;
    logic [2:0]  cnt_q;
    logic [3:0]  idx_q;
    logic [31:0] acc_q;
    logic [15:0] rem_q;
    logic        bfinal_q;
    logic [31:0] crc_q;
    logic [31:0] isize_q;
    logic [7:0]  m_dat_q;
    logic        m_vld_q;
    logic        m_last_q;
    logic        done_q;
    logic        error_q;
    logic [2:0]  err_code_q;

    logic [7:0]  cur_byte;
    logic        consume;
    logic        load;
    logic        s_rdy;
    logic [31:0] acc_full;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'd0, d};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction

    always_comb begin
        cur_byte = hold_q[7:0];
        consume  = 1'b0;
        case (state_q)
            S_HDR, S_BLK, S_LEN, S_TRL: consume = (cnt_q != 3'd0);
            S_DATA:                     consume = (cnt_q != 3'd0) && (!m_vld_q || bus.m_axis_tready);
            default:                    consume = 1'b0;
        endcase
        // Gated by rst_n so the source never sees ready while the block is held in reset.
        s_rdy    = rst_n && (state_q != S_DONE) && (state_q != S_ERR) &&
                   ((cnt_q == 3'd0) || ((cnt_q == 3'd1) && consume));
        load     = bus.s_axis_tvalid && s_rdy;
        acc_full = {cur_byte, acc_q[31:8]};
    end

    always_comb begin
        state_d = state_q;
        code_d  = 3'd0;
        case (state_q)
            S_HDR: if (consume) begin
                if ((idx_q == 4'd0 && cur_byte != 8'h1F) ||
                    (idx_q == 4'd1 && cur_byte != 8'h8B) ||
                    (idx_q == 4'd2 && cur_byte != 8'h08)) begin
                    state_d = S_ERR;
                    code_d  = 3'd1;
                end else if (idx_q == 4'd3 && cur_byte != 8'h00) begin
                    state_d = S_ERR;
                    code_d  = 3'd2;
                end else if (idx_q == 4'd9) begin
                    state_d = S_BLK;
                end
            end
            S_BLK: if (consume) begin
                if (cur_byte[2:1] != 2'b00) begin
                    state_d = S_ERR;
                    code_d  = 3'd3;
                end else begin
                    state_d = S_LEN;
                end
            end
            S_LEN: if (consume && idx_q == 4'd3) begin
                if (acc_full[31:16] != ~acc_full[15:0]) begin
                    state_d = S_ERR;
                    code_d  = 3'd4;
                end else if (acc_full[15:0] == 16'd0) begin
                    state_d = bfinal_q ? S_TRL : S_BLK;
                end else begin
                    state_d = S_DATA;
                end
            end
            S_DATA: if (consume && rem_q == 16'd1) begin
                state_d = bfinal_q ? S_TRL : S_BLK;
            end
            S_TRL: if (consume) begin
                if (idx_q == 4'd3 && acc_full != ~crc_q) begin
                    state_d = S_ERR;
                    code_d  = 3'd5;
                end else if (idx_q == 4'd7 && acc_full != isize_q) begin
                    state_d = S_ERR;
                    code_d  = 3'd6;
                end else if (idx_q == 4'd7) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = state_q;
        endcase
    end

    always_ff @(posedge core_clock or negedge rst_n) begin
        if (!rst_n) state_q <= S_HDR;
        else        state_q <= state_d;
    end

    always_ff @(posedge core_clock or negedge rst_n) begin
        if (!rst_n) begin
            hold_q     <= 32'd0;
            cnt_q      <= 3'd0;
            idx_q      <= 4'd0;
            acc_q      <= 32'd0;
            rem_q      <= 16'd0;
            bfinal_q   <= 1'b0;
            crc_q      <= 32'hFFFFFFFF;
            isize_q    <= 32'd0;
            m_dat_q    <= 8'd0;
            m_vld_q    <= 1'b0;
            m_last_q   <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            err_code_q <= 3'd0;
        end else begin
            if (load) begin
                hold_q <= bus.s_axis_tdata;
                cnt_q  <= 3'd4;
            end else if (state_d == S_DONE || state_d == S_ERR) begin
                cnt_q  <= 3'd0;
            end else if (consume) begin
                hold_q <= hold_q >> 8;
                cnt_q  <= cnt_q - 3'd1;
            end

            // Index restarts on every state change; LEN and TRL fields assemble LSB first in acc_q.
            if (state_d != state_q) idx_q <= 4'd0;
            else if (consume)       idx_q <= idx_q + 4'd1;
            if (consume) acc_q <= acc_full;

            if (state_q == S_BLK && consume) bfinal_q <= cur_byte[0];
            if (state_q == S_LEN && consume && idx_q == 4'd3) rem_q <= acc_full[15:0];

            if (state_q == S_DATA && consume) begin
                rem_q    <= rem_q - 16'd1;
                m_dat_q  <= cur_byte;
                m_vld_q  <= 1'b1;
                m_last_q <= bfinal_q && (rem_q == 16'd1);
                crc_q    <= crc_byte(crc_q, cur_byte);
                isize_q  <= isize_q + 32'd1;
            end else if (bus.m_axis_tready) begin
                m_vld_q  <= 1'b0;
                m_last_q <= 1'b0;
            end

            if (state_d == S_DONE) done_q  <= 1'b1;
            if (state_d == S_ERR)  error_q <= 1'b1;
            if (code_d != 3'd0)    err_code_q <= code_d;
        end
    end

    assign bus.s_axis_tready = s_rdy;
    assign bus.m_axis_tdata  = m_dat_q;
    assign bus.m_axis_tvalid = m_vld_q;
    assign bus.m_axis_tlast  = m_last_q;
    assign bus.done          = done_q;
    assign bus.error         = error_q;
    assign bus.err_code      = err_code_q;
    assign bus.crc32         = ~crc_q;
    assign bus.isize         = isize_q;

endmodule

// File: tb/tb_gunzip_stored.sv
// Bench for gunzip_stored: a member-level parser model predicts payload, flags and checksums,
// and a per-cycle monitor compares every output transfer and stall against it.
module tb_gunzip_stored;

    typedef logic [7:0] bq_t[$];

    logic core_clock = 1'b0;
    logic rst_n      = 1'b0;

    gunzip_stored_if bus ();

    gunzip_stored dut (
        .core_clock (core_clock),
        .rst_n      (rst_n),
        .bus        (bus)
    );

    always #5 core_clock = ~core_clock;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          rx_cnt   = 0;
    bit          abort    = 1'b0;
    bit          toggle_rdy = 1'b0;
    logic [8:0]  exp_q[$];
    bit          exp_done;
    logic [2:0]  exp_code;
    logic [31:0] exp_crc;
    logic [31:0] exp_isize;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bq_t mk(input int n, input logic [255:0] v);
        bq_t q;
        for (int i = 0; i < n; i++) q.push_back(v[8*(n-1-i) +: 8]);
        return q;
    endfunction

    function automatic bq_t cat(input bq_t a, input bq_t b);
        bq_t q;
        q = a;
        foreach (b[i]) q.push_back(b[i]);
        return q;
    endfunction

    // Bitwise reflected CRC-32 over a whole message.
    function automatic logic [31:0] crc_model(input bq_t d);
        logic [31:0] c;
        logic        fb;
        c = 32'hFFFFFFFF;
        foreach (d[k]) begin
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ d[k][b];
                c  = (c >> 1) ^ (fb ? 32'hEDB88320 : 32'h0);
            end
        end
        return ~c;
    endfunction

    // Walks the member field by field and derives every expected output.
    task automatic model(input bq_t m);
        int          p;
        bit          fin;
        logic [15:0] len;
        logic [15:0] nlen;
        logic [31:0] t_crc;
        logic [31:0] t_isz;
        bq_t         pay;
        exp_q.delete();
        exp_code = 3'd0;
        p = 0;
        if (m[0] != 8'h1F || m[1] != 8'h8B || m[2] != 8'h08) exp_code = 3'd1;
        else if (m[3] != 8'h00) exp_code = 3'd2;
        else begin
            p   = 10;
            fin = 1'b0;
            while (!fin && exp_code == 3'd0) begin
                fin = m[p][0];
                if (m[p][2:1] != 2'b00) exp_code = 3'd3;
                else begin
                    len  = {m[p+2], m[p+1]};
                    nlen = {m[p+4], m[p+3]};
                    p    = p + 5;
                    if (nlen != ~len) exp_code = 3'd4;
                    else begin
                        for (int i = 0; i < int'(len); i++) begin
                            pay.push_back(m[p+i]);
                            exp_q.push_back({fin && (i == int'(len) - 1), m[p+i]});
                        end
                        p = p + int'(len);
                    end
                end
            end
        end
        exp_crc   = crc_model(pay);
        exp_isize = 32'(pay.size());
        if (exp_code == 3'd0) begin
            t_crc = {m[p+3], m[p+2], m[p+1], m[p]};
            t_isz = {m[p+7], m[p+6], m[p+5], m[p+4]};
            if (t_crc != exp_crc)        exp_code = 3'd5;
            else if (t_isz != exp_isize) exp_code = 3'd6;
        end
        exp_done = (exp_code == 3'd0);
    endtask

    initial begin
        bus.m_axis_tready = 1'b1;
        forever begin
            @(posedge core_clock);
            #1;
            bus.m_axis_tready = toggle_rdy ? ~bus.m_axis_tready : 1'b1;
        end
    end

    // Output monitor: every transfer against the model, every stall for stability.
    initial begin
        logic       prev_stall;
        logic [7:0] prev_dat;
        logic       prev_last;
        logic [8:0] e;
        prev_stall = 1'b0;
        prev_dat   = 8'd0;
        prev_last  = 1'b0;
        forever begin
            @(negedge core_clock);
            if (!rst_n) prev_stall = 1'b0;
            else begin
                if (prev_stall) begin
                    chk("stall_vld",  32'(bus.m_axis_tvalid), 32'd1);
                    chk("stall_dat",  32'(bus.m_axis_tdata), 32'(prev_dat));
                    chk("stall_last", 32'(bus.m_axis_tlast), 32'(prev_last));
                end
                if (bus.m_axis_tvalid && bus.m_axis_tready) begin
                    rx_cnt++;
                    if (exp_q.size() == 0) begin
                        chk("extra_byte", 32'(bus.m_axis_tdata), 32'hFFFFFFFF);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_dat",  32'(bus.m_axis_tdata), 32'(e[7:0]));
                        chk("out_last", 32'(bus.m_axis_tlast), 32'(e[8]));
                    end
                end
                prev_stall = bus.m_axis_tvalid && !bus.m_axis_tready;
                prev_dat   = bus.m_axis_tdata;
                prev_last  = bus.m_axis_tlast;
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tdata  = 32'd0;
        repeat (2) @(posedge core_clock);
        exp_q.delete();
        @(negedge core_clock);
        chk("rst_s_rdy",  32'(bus.s_axis_tready), 32'd0);
        chk("rst_m_vld",  32'(bus.m_axis_tvalid), 32'd0);
        chk("rst_m_last", 32'(bus.m_axis_tlast), 32'd0);
        chk("rst_m_dat",  32'(bus.m_axis_tdata), 32'd0);
        chk("rst_done",   32'(bus.done), 32'd0);
        chk("rst_error",  32'(bus.error), 32'd0);
        chk("rst_code",   32'(bus.err_code), 32'd0);
        chk("rst_crc",    bus.crc32, 32'd0);
        chk("rst_isize",  bus.isize, 32'd0);
        @(posedge core_clock);
        #1;
        rst_n = 1'b1;
        abort = 1'b0;
        rx_cnt = 0;
    endtask

    task automatic send(input bq_t m, input bit gap);
        bq_t q;
        bit  ok;
        q = m;
        while (q.size() % 4 != 0) q.push_back(8'h00);
        for (int w = 0; w < q.size() / 4; w++) begin
            if (abort || bus.done || bus.error) break;
            if (gap && (w % 2 == 1)) begin
                bus.s_axis_tvalid = 1'b0;
                @(posedge core_clock);
                #1;
            end
            bus.s_axis_tdata  = {q[4*w+3], q[4*w+2], q[4*w+1], q[4*w]};
            bus.s_axis_tvalid = 1'b1;
            ok = 1'b0;
            for (int t = 0; t < 200; t++) begin
                @(negedge core_clock);
                if (abort || bus.done || bus.error) break;
                if (bus.s_axis_tready) begin
                    ok = 1'b1;
                    break;
                end
            end
            if (!ok) begin
                if (!abort && !bus.done && !bus.error) chk("word_accept", 32'(ok), 32'd1);
                break;
            end
            @(posedge core_clock);
            #1;
        end
        bus.s_axis_tvalid = 1'b0;
    endtask

    task automatic finish_check(input string tag, input logic [2:0] lit_code);
        bit ended;
        ended = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge core_clock);
            if (bus.done || bus.error) begin
                ended = 1'b1;
                break;
            end
        end
        if (!ended) chk({tag, "_end_timeout"}, 32'(ended), 32'd1);
        repeat (6) @(negedge core_clock);
        chk({tag, "_done"},     32'(bus.done), 32'(exp_done));
        chk({tag, "_error"},    32'(bus.error), 32'(!exp_done));
        chk({tag, "_code"},     32'(bus.err_code), 32'(exp_code));
        chk({tag, "_code_lit"}, 32'(bus.err_code), 32'(lit_code));
        chk({tag, "_crc"},      bus.crc32, exp_crc);
        chk({tag, "_isize"},    bus.isize, exp_isize);
        chk({tag, "_s_rdy"},    32'(bus.s_axis_tready), 32'd0);
        chk({tag, "_missing"},  32'(exp_q.size()), 32'd0);
        chk({tag, "_drained"},  32'(bus.m_axis_tvalid), 32'd0);
    endtask

    task automatic run(input string tag, input bq_t m, input bit gap, input bit tog,
                       input logic [2:0] lit_code);
        do_reset();
        toggle_rdy = tog;
        model(m);
        send(m, gap);
        finish_check(tag, lit_code);
        toggle_rdy = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1);
    end

    initial begin
        bq_t hdr, blk_abc, trl, s1, s2, s5, e;
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tdata  = 32'd0;

        hdr     = mk(10, 256'h1F8B0800000000000003);
        blk_abc = mk(8,  256'h010300FCFF616263);
        trl     = mk(8,  256'hC241243503000000);
        s1      = cat(cat(hdr, blk_abc), trl);

        chk("model_crc_abc", crc_model(mk(3, 256'h616263)), 32'h352441C2);
        model(s1);
        chk("model_s1_bytes", 32'(exp_q.size()), 32'd3);
        chk("model_s1_last",  32'(exp_q[2]), 32'h163);

        run("s1", s1, 1'b0, 1'b0, 3'd0);
        chk("s1_crc_lit",   bus.crc32, 32'h352441C2);
        chk("s1_isize_lit", bus.isize, 32'd3);
        chk("s1_done_lit",  32'(bus.done), 32'd1);

        s2 = cat(cat(cat(hdr, mk(7, 256'h000200FDFF6162)), mk(6, 256'h010100FEFF63)), trl);
        run("s2", s2, 1'b0, 1'b0, 3'd0);
        chk("s2_done_lit", 32'(bus.done), 32'd1);

        run("s3", s1, 1'b1, 1'b1, 3'd0);
        chk("s3_crc_lit", bus.crc32, 32'h352441C2);

        e = cat(cat(mk(10, 256'h1F8C0800000000000003), blk_abc), trl);
        run("e1", e, 1'b0, 1'b0, 3'd1);
        e = cat(cat(mk(10, 256'h1F8B0808000000000003), blk_abc), trl);
        run("e2", e, 1'b0, 1'b0, 3'd2);
        e = cat(cat(hdr, mk(8, 256'h030300FCFF616263)), trl);
        run("e3", e, 1'b0, 1'b0, 3'd3);
        e = cat(cat(hdr, mk(8, 256'h010300FEFC616263)), trl);
        run("e4", e, 1'b0, 1'b0, 3'd4);
        e = cat(cat(hdr, blk_abc), mk(8, 256'hC341243503000000));
        run("e5", e, 1'b0, 1'b0, 3'd5);
        e = cat(cat(hdr, blk_abc), mk(8, 256'hC241243504000000));
        run("e6", e, 1'b0, 1'b0, 3'd6);

        s5 = cat(cat(hdr, mk(5, 256'h010000FFFF)), mk(8, 256'h0));
        run("s5", s5, 1'b0, 1'b0, 3'd0);
        chk("s5_crc_lit",   bus.crc32, 32'h0);
        chk("s5_isize_lit", bus.isize, 32'd0);
        chk("s5_rx_lit",    32'(rx_cnt), 32'd0);

        // Reset once byte 62 has been taken, while 63 sits in the output register.
        do_reset();
        model(s1);
        fork
            send(s1, 1'b0);
            begin
                for (int i = 0; i < 300; i++) begin
                    @(posedge core_clock);
                    #2;
                    if (rx_cnt >= 2) break;
                end
                chk("s6_reached_62", 32'(rx_cnt >= 2), 32'd1);
                abort = 1'b1;
                rst_n = 1'b0;
                #1;
                chk("s6_async_vld",   32'(bus.m_axis_tvalid), 32'd0);
                chk("s6_async_isize", bus.isize, 32'd0);
            end
        join
        run("s6_replay", s1, 1'b0, 1'b0, 3'd0);
        chk("s6_crc_lit", bus.crc32, 32'h352441C2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
